// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the note sequencer and its song ROM.
package note_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2
   } seq_state_e;

   localparam int unsigned NOTE_C4   = 262;
   localparam int unsigned NOTE_D4   = 294;
   localparam int unsigned NOTE_E4   = 330;
   localparam int unsigned NOTE_G4   = 392;
   localparam int unsigned NOTE_REST = 0;

   localparam int unsigned LAST_BEAT_DEFAULT = 660;

endpackage

// File: rtl/note_sequencer_if.sv
// Command/status bundle between a player controller and the note sequencer.
interface note_sequencer_if #(
   parameter int unsigned IBEAT_W = 10,
   parameter int unsigned TONE_W  = 32
);

   logic               beat_tick;
   logic               play;
   logic               pause;
   logic               stop;
   logic               loop_en;
   logic               song_sel;
   logic [IBEAT_W-1:0] ibeat;
   logic [TONE_W-1:0]  tone;
   logic               tone_valid;
   logic               busy;
   logic               song_done;

   modport master (
      output beat_tick, play, pause, stop, loop_en, song_sel,
      input  ibeat, tone, tone_valid, busy, song_done
   );

   modport slave (
      input  beat_tick, play, pause, stop, loop_en, song_sel,
      output ibeat, tone, tone_valid, busy, song_done
   );

endinterface

// File: rtl/note_sequencer_song_rom.sv
// Combinational melody store: two short songs, silence past the written notes.
module song_rom
   import note_pkg::*;
#(
   parameter int unsigned IBEAT_W = 10,
   parameter int unsigned TONE_W  = 32
) (
   input  logic               song,
   input  logic [IBEAT_W-1:0] ibeat,
   output logic [TONE_W-1:0]  tone
);

   // Only beats 0..3 carry notes; everything above is a rest.
   always_comb begin
      tone = TONE_W'(NOTE_REST);
      if ((ibeat >> 2) == '0) begin
         unique case ({song, ibeat[1:0]})
            3'b0_00: tone = TONE_W'(NOTE_C4);
            3'b0_01: tone = TONE_W'(NOTE_C4);
            3'b0_10: tone = TONE_W'(NOTE_D4);
            3'b0_11: tone = TONE_W'(NOTE_REST);
            3'b1_00: tone = TONE_W'(NOTE_G4);
            3'b1_01: tone = TONE_W'(NOTE_E4);
            3'b1_10: tone = TONE_W'(NOTE_E4);
            3'b1_11: tone = TONE_W'(NOTE_REST);
            default: tone = TONE_W'(NOTE_REST);
         endcase
      end
   end

endmodule

// File: rtl/note_sequencer.sv
// Beat-driven song sequencer: play/pause/stop/loop control and registered tone output.
module note_sequencer
   import note_pkg::*;
#(
   parameter int unsigned LAST_BEAT = LAST_BEAT_DEFAULT,
   parameter int unsigned IBEAT_W   = 10,
   parameter int unsigned TONE_W    = 32
) (
   input  logic            clk,
   input  logic            reset,
   note_sequencer_if.slave bus
);

   seq_state_e         state_q, state_d;
   logic [IBEAT_W-1:0] ibeat_q, ibeat_d;
   logic               song_q, song_d;
   logic               done_q, done_d;
   logic [TONE_W-1:0]  tone_q, tone_d;
   logic               tone_valid_q;
   logic               busy_q;
   logic [TONE_W-1:0]  rom_tone;
   logic               at_last;

   song_rom #(
      .IBEAT_W (IBEAT_W),
      .TONE_W  (TONE_W)
   ) u_song_rom (
      .song  (song_q),
      .ibeat (ibeat_q),
      .tone  (rom_tone)
   );

   assign at_last = (ibeat_q == IBEAT_W'(LAST_BEAT));

   // Next state: stop beats pause beats play beats beat_tick; accepted commands swallow the tick.
   always_comb begin
      state_d = state_q;
      ibeat_d = ibeat_q;
      song_d  = song_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.play) begin
               song_d  = bus.song_sel;
               ibeat_d = '0;
               state_d = PLAY;
            end
         end
         PLAY: begin
            if (bus.stop) begin
               state_d = IDLE;
               ibeat_d = '0;
            end else if (bus.pause) begin
               state_d = PAUSE;
            end else if (bus.beat_tick) begin
               if (at_last) begin
                  done_d  = 1'b1;
                  ibeat_d = '0;
                  if (!bus.loop_en) state_d = IDLE;
               end else begin
                  ibeat_d = ibeat_q + 1'b1;
               end
            end
         end
         PAUSE: begin
            if (bus.stop) begin
               state_d = IDLE;
               ibeat_d = '0;
            end else if (!bus.pause && bus.play) begin
               state_d = PLAY;
            end
         end
         default: begin
            state_d = IDLE;
            ibeat_d = '0;
         end
      endcase
   end

   // Tone follows the beat that was current while playing, one cycle late.
   always_comb begin
      tone_d = (state_q == PLAY) ? rom_tone : '0;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         ibeat_q      <= '0;
         song_q       <= 1'b0;
         done_q       <= 1'b0;
         tone_q       <= '0;
         tone_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ibeat_q      <= ibeat_d;
         song_q       <= song_d;
         done_q       <= done_d;
         tone_q       <= tone_d;
         tone_valid_q <= (tone_d != '0);
         busy_q       <= (state_d != IDLE);
      end
   end

   assign bus.ibeat      = ibeat_q;
   assign bus.tone       = tone_q;
   assign bus.tone_valid = tone_valid_q;
   assign bus.busy       = busy_q;
   assign bus.song_done  = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios plus random commands vs. a model.
module tb_note_sequencer;

   localparam int unsigned LAST = 3;

   logic clk;
   logic reset;

   note_sequencer_if #(.IBEAT_W(10), .TONE_W(32)) bus ();

   note_sequencer #(
      .LAST_BEAT (LAST),
      .IBEAT_W   (10),
      .TONE_W    (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: state as plain ints, melodies as tables.
   localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2;
   int m_state, m_ibeat, m_song, m_tone, m_done;

   function automatic int melody(input int song, input int beat);
      int s0 [4] = '{262, 262, 294, 0};
      int s1 [4] = '{392, 330, 330, 0};
      if (beat > 3) return 0;
      return (song == 0) ? s0[beat] : s1[beat];
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model, compare every output.
   task automatic step(input logic t, input logic pl, input logic pa, input logic st,
                       input logic lp, input logic ss, input logic rst);
      bus.beat_tick = t;
      bus.play      = pl;
      bus.pause     = pa;
      bus.stop      = st;
      bus.loop_en   = lp;
      bus.song_sel  = ss;
      reset         = rst;
      @(posedge clk);
      if (rst) begin
         m_state = M_IDLE; m_ibeat = 0; m_song = 0; m_tone = 0; m_done = 0;
      end else begin
         m_tone = (m_state == M_PLAY) ? melody(m_song, m_ibeat) : 0;
         m_done = 0;
         case (m_state)
            M_IDLE: if (pl) begin m_song = int'(ss); m_ibeat = 0; m_state = M_PLAY; end
            M_PLAY: begin
               if (st) begin m_state = M_IDLE; m_ibeat = 0; end
               else if (pa) m_state = M_PAUSE;
               else if (t) begin
                  if (m_ibeat == LAST) begin
                     m_done = 1; m_ibeat = 0;
                     if (!lp) m_state = M_IDLE;
                  end else m_ibeat++;
               end
            end
            default: begin
               if (st) begin m_state = M_IDLE; m_ibeat = 0; end
               else if (!pa && pl) m_state = M_PLAY;
            end
         endcase
      end
      #1;
      check_eq("ibeat", 32'(bus.ibeat), 32'(m_ibeat));
      check_eq("tone", bus.tone, 32'(m_tone));
      check_eq("tone_valid", 32'(bus.tone_valid), 32'(m_tone != 0));
      check_eq("busy", 32'(bus.busy), 32'(m_state != M_IDLE));
      check_eq("song_done", 32'(bus.song_done), 32'(m_done));
   endtask

   task automatic idle(input int n, input logic lp);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, lp, 0, 0);
   endtask

   initial begin
      int exp_tone [4] = '{262, 262, 294, 0};
      m_state = M_IDLE; m_ibeat = 0; m_song = 0; m_tone = 0; m_done = 0;

      // Reset values.
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      check_eq("rst_ibeat", 32'(bus.ibeat), 0);
      check_eq("rst_tone", bus.tone, 0);
      check_eq("rst_busy", 32'(bus.busy), 0);
      check_eq("rst_done", 32'(bus.song_done), 0);

      // Song 0, tick every 4 cycles.
      step(0, 1, 0, 0, 0, 0, 0);
      check_eq("s0_start_ibeat", 32'(bus.ibeat), 0);
      check_eq("s0_start_busy", 32'(bus.busy), 1);
      idle(1, 0);
      check_eq("s0_tone0", bus.tone, 262);
      for (int b = 1; b <= 3; b++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         check_eq("s0_ibeat", 32'(bus.ibeat), 32'(b));
         idle(1, 0);
         check_eq("s0_tone", bus.tone, 32'(exp_tone[b]));
         idle(2, 0);
      end
      check_eq("s0_valid_rest", 32'(bus.tone_valid), 0);
      // Last beat, no loop.
      step(1, 0, 0, 0, 0, 0, 0);
      check_eq("end_done", 32'(bus.song_done), 1);
      check_eq("end_ibeat", 32'(bus.ibeat), 0);
      check_eq("end_busy", 32'(bus.busy), 0);
      idle(1, 0);
      check_eq("end_done_pulse", 32'(bus.song_done), 0);
      check_eq("end_tone", bus.tone, 0);

      // Song 1 with loop.
      step(0, 1, 0, 0, 1, 1, 0);
      for (int b = 0; b < 3; b++) step(1, 0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 1, 1, 0);
      check_eq("loop_done", 32'(bus.song_done), 1);
      check_eq("loop_ibeat", 32'(bus.ibeat), 0);
      check_eq("loop_busy", 32'(bus.busy), 1);
      idle(1, 1);
      check_eq("loop_tone", bus.tone, 392);

      // Pause at beat 2 of song 0.
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 1, 0);
      idle(1, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      idle(1, 0);
      check_eq("pause_tone", bus.tone, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0);
      check_eq("pause_ibeat", 32'(bus.ibeat), 2);
      step(0, 1, 0, 0, 0, 0, 0);
      check_eq("resume_ibeat", 32'(bus.ibeat), 2);
      idle(1, 0);
      check_eq("resume_tone", bus.tone, 294);

      // All commands plus tick at once: stop wins.
      step(1, 1, 1, 1, 0, 0, 0);
      check_eq("prio_ibeat", 32'(bus.ibeat), 0);
      check_eq("prio_busy", 32'(bus.busy), 0);
      check_eq("prio_done", 32'(bus.song_done), 0);

      // Reset mid-song while looping.
      step(0, 1, 0, 0, 1, 1, 0);
      step(1, 0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 1, 0, 0);
      step(1, 1, 0, 0, 1, 0, 1);
      check_eq("mid_rst_ibeat", 32'(bus.ibeat), 0);
      check_eq("mid_rst_tone", bus.tone, 0);
      check_eq("mid_rst_busy", 32'(bus.busy), 0);

      // Random commands, ticks, loop changes and song_sel toggling.
      begin
         logic lp;
         lp = 1'b0;
         for (int i = 0; i < 4000; i++) begin
            int r;
            logic t, pl, pa, st, rs;
            r  = int'($urandom_range(0, 99));
            pl = (r < 3);
            pa = (r >= 3 && r < 5);
            st = (r == 5);
            t  = ($urandom_range(0, 9) < 4);
            rs = ($urandom_range(0, 999) < 2);
            if ($urandom_range(0, 49) == 0) lp = ~lp;
            step(t, pl, pa, st, lp, 1'($urandom), rs);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
